sgpr_bank_file: RTL and testbench

//  Multi-wavefront scalar register file for the Scalar ALU. It holds SGPRs, VCC, M0, EXEC and SCC
//  for NUM_WAVES wavefronts and serves 2 registered read ports plus 1 write port using the RDNA2
//  8-bit scalar operand encoding. It adds same-cycle write bypass, inline-constant decode,

---
 rtl/sgpr_bank_file_pkg.sv | 39 +++
 rtl/sgpr_bank_file_if.sv | 46 ++++
 rtl/sgpr_bank_file_const_decode.sv | 27 ++
 rtl/sgpr_bank_file.sv | 228 ++++++++++++++++++++++
 tb/tb_sgpr_bank_file.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sgpr_bank_file_pkg.sv
// sgpr_pkg: shared definitions for the scalar register file.
//   - RDNA2 8-bit scalar operand address map (named registers, inline
//     constant range, status pseudo-registers)
//   - is_writable(): true for addresses that map onto real storage
//   - is_const():    true for the inline integer constant range
package sgpr_pkg;

  localparam logic [7:0] VCC_LO        = 8'd106;
  localparam logic [7:0] VCC_HI        = 8'd107;
  localparam logic [7:0] M0            = 8'd124;
  localparam logic [7:0] NULL          = 8'd125;
  localparam logic [7:0] EXEC_LO       = 8'd126;
  localparam logic [7:0] EXEC_HI       = 8'd127;
  localparam logic [7:0] CONST_POS_MIN = 8'd128;  // integer 0
  localparam logic [7:0] CONST_POS_MAX = 8'd192;  // integer 64
  localparam logic [7:0] CONST_NEG_MIN = 8'd193;  // integer -1
  localparam logic [7:0] CONST_NEG_MAX = 8'd208;  // integer -16
  localparam logic [7:0] VCCZ          = 8'd251;
  localparam logic [7:0] EXECZ         = 8'd252;
  localparam logic [7:0] SCC           = 8'd253;

  // Storage words per wave: every writable address is below 128.
  localparam int BANK_WORDS = 128;

  // Addresses backed by storage: the SGPRs plus VCC, M0 and EXEC halves.
  function automatic logic is_writable(logic [7:0] a, int num_sgpr);
    logic ok;
    ok = (int'({24'h0, a}) < num_sgpr) ||
         (a == VCC_LO) || (a == VCC_HI) || (a == M0) ||
         (a == EXEC_LO) || (a == EXEC_HI);
    return ok;
  endfunction

  // Inline integer constants 0..64 and -1..-16 occupy one contiguous range.
  function automatic logic is_const(logic [7:0] a);
    return (a >= CONST_POS_MIN) && (a <= CONST_NEG_MAX);
  endfunction

endpackage

// File: rtl/sgpr_bank_file_if.sv
// sgpr_bank_file_if: read/write/status bundle of the scalar register file.
//   master: the Scalar ALU side (drives requests, receives read data)
//   slave : the register file (receives requests, drives results)
//   Read:  rd_valid, rd_wave, rd_addr0/1, rd_wide0/1 -> rd_data0/1, rd_ready
//   Write: wr_en, wr_wave, wr_addr, wr_wide, wr_data -> wr_err
//   SCC:   scc_we, scc_in
//   Status of rd_wave: scc_out, vccz_out, execz_out, exec_out
interface sgpr_bank_file_if #(
  parameter int WAVE_W = 2
);
  logic              rd_valid;
  logic [WAVE_W-1:0] rd_wave;
  logic [7:0]        rd_addr0;
  logic [7:0]        rd_addr1;
  logic              rd_wide0;
  logic              rd_wide1;
  logic [63:0]       rd_data0;
  logic [63:0]       rd_data1;
  logic              rd_ready;
  logic              wr_en;
  logic [WAVE_W-1:0] wr_wave;
  logic [7:0]        wr_addr;
  logic              wr_wide;
  logic [63:0]       wr_data;
  logic              wr_err;
  logic              scc_we;
  logic              scc_in;
  logic              scc_out;
  logic              vccz_out;
  logic              execz_out;
  logic [63:0]       exec_out;

  modport master (
    output rd_valid, rd_wave, rd_addr0, rd_addr1, rd_wide0, rd_wide1,
    output wr_en, wr_wave, wr_addr, wr_wide, wr_data, scc_we, scc_in,
    input  rd_data0, rd_data1, rd_ready, wr_err,
    input  scc_out, vccz_out, execz_out, exec_out
  );

  modport slave (
    input  rd_valid, rd_wave, rd_addr0, rd_addr1, rd_wide0, rd_wide1,
    input  wr_en, wr_wave, wr_addr, wr_wide, wr_data, scc_we, scc_in,
    output rd_data0, rd_data1, rd_ready, wr_err,
    output scc_out, vccz_out, execz_out, exec_out
  );
endinterface

// File: rtl/sgpr_bank_file_const_decode.sv
// sgpr_const_decode: combinational inline-constant decoder.
//   addr      in  8   scalar operand address
//   const_hit out 1   addr lies in 128..208
//   value     out 64  sign-extended integer (0..64 or -1..-16), 0 otherwise
module sgpr_const_decode
  import sgpr_pkg::*;
(
  input  logic [7:0]  addr,
  output logic        const_hit,
  output logic [63:0] value
);

  // Map the address onto its 64-bit integer value.
  always_comb begin
    const_hit = is_const(addr);
    value     = 64'h0;
    if ((addr >= CONST_POS_MIN) && (addr <= CONST_POS_MAX)) begin
      value = {56'h0, addr - CONST_POS_MIN};
    end else if ((addr >= CONST_NEG_MIN) && (addr <= CONST_NEG_MAX)) begin
      // 193 -> -1 ... 208 -> -16
      value = 64'h0 - {56'h0, addr - CONST_POS_MAX};
    end else begin
      value = 64'h0;
    end
  end

endmodule

// File: rtl/sgpr_bank_file.sv
// sgpr_bank_file: multi-wavefront scalar register file.
//   clock   in  rising-edge clock
//   reset_n in  asynchronous active-low reset
//   bus     slave modport of sgpr_bank_file_if (2 read ports, 1 write
//           port, SCC update, registered status of the read wave)
// Reads are write-first: the read lanes look at the post-write bank image,
// so a same-cycle write to the same wave/word is returned per 32-bit half,
// and VCCZ/EXECZ/SCC reflect post-write state as well.
module sgpr_bank_file
  import sgpr_pkg::*;
#(
  parameter int NUM_WAVES = 4,
  parameter int NUM_SGPR  = 106,
  parameter int WAVE_W    = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  sgpr_bank_file_if.slave  bus
);

  logic [31:0] regs_q [NUM_WAVES][BANK_WORDS];
  logic [31:0] regs_d [NUM_WAVES][BANK_WORDS];
  logic [NUM_WAVES-1:0] scc_q, scc_d;

  logic        wr_err_q, wr_err_d;
  logic        rd_ready_q, rd_ready_d;
  logic [63:0] rd_data0_q, rd_data0_d;
  logic [63:0] rd_data1_q, rd_data1_d;
  logic [63:0] exec_q, exec_d;
  logic        scc_out_q, scc_out_d;
  logic        vccz_q, vccz_d;
  logic        execz_q, execz_d;

  logic [WAVE_W-1:0] rd_wave_s, wr_wave_s;
  logic [7:0]        wr_addr_p1_s;
  logic              wr_lo_en_s, wr_hi_en_s;

  // Read lanes: port0 lo/hi, port1 lo/hi, VCC lo/hi, EXEC lo/hi.
  logic [7:0]  lane_addr_s [8];
  logic [31:0] lane_val_s  [8];
  logic [63:0] vcc_s, exec_s;
  logic        vccz_s, execz_s, scc_s;

  logic        c0_hit_s, c1_hit_s;
  logic [63:0] c0_val_s, c1_val_s;

  assign rd_wave_s = bus.rd_wave;
  assign wr_wave_s = bus.wr_wave;

  sgpr_const_decode u_const0 (
    .addr      (bus.rd_addr0),
    .const_hit (c0_hit_s),
    .value     (c0_val_s)
  );

  sgpr_const_decode u_const1 (
    .addr      (bus.rd_addr1),
    .const_hit (c1_hit_s),
    .value     (c1_val_s)
  );

  // Final per-port result from the operand class of the address.
  function automatic logic [63:0] sel_port(
    logic [7:0]  a,
    logic        wide,
    logic [31:0] lo,
    logic [31:0] hi,
    logic        c_hit,
    logic [63:0] c_val,
    logic        vccz,
    logic        execz,
    logic        scc,
    int          num_sgpr
  );
    logic [63:0] r;
    r = 64'h0;
    if (is_writable(a, num_sgpr)) begin
      if (wide) r = {hi, lo};
      else      r = {32'h0, lo};
    end else if (c_hit) begin
      if (wide) r = c_val;
      else      r = {32'h0, c_val[31:0]};
    end else begin
      case (a)
        VCCZ:    r = {63'h0, vccz};
        EXECZ:   r = {63'h0, execz};
        SCC:     r = {63'h0, scc};
        default: r = 64'h0;  // NULL and unmapped addresses
      endcase
    end
    return r;
  endfunction

  // Write legality; a wide write must be even-aligned with both halves legal.
  always_comb begin
    wr_addr_p1_s = bus.wr_addr + 8'd1;
    wr_lo_en_s   = 1'b0;
    wr_hi_en_s   = 1'b0;
    wr_err_d     = 1'b0;
    if (bus.wr_en) begin
      if (bus.wr_wide) begin
        if (!bus.wr_addr[0] && is_writable(bus.wr_addr, NUM_SGPR) &&
            is_writable(wr_addr_p1_s, NUM_SGPR)) begin
          wr_lo_en_s = 1'b1;
          wr_hi_en_s = 1'b1;
        end else begin
          wr_err_d = 1'b1;
        end
      end else begin
        if (is_writable(bus.wr_addr, NUM_SGPR)) begin
          wr_lo_en_s = 1'b1;
        end else begin
          wr_err_d = 1'b1;
        end
      end
    end else begin
      wr_err_d = 1'b0;
    end
  end

  // Post-write bank and SCC image; also the source for write-first reads.
  always_comb begin
    regs_d = regs_q;
    scc_d  = scc_q;
    if (wr_lo_en_s) begin
      regs_d[wr_wave_s][bus.wr_addr[6:0]] = bus.wr_data[31:0];
    end else begin
      regs_d[wr_wave_s][bus.wr_addr[6:0]] = regs_q[wr_wave_s][bus.wr_addr[6:0]];
    end
    if (wr_hi_en_s) begin
      regs_d[wr_wave_s][wr_addr_p1_s[6:0]] = bus.wr_data[63:32];
    end else begin
      regs_d[wr_wave_s][wr_addr_p1_s[6:0]] = regs_q[wr_wave_s][wr_addr_p1_s[6:0]];
    end
    if (bus.scc_we) begin
      scc_d[wr_wave_s] = bus.scc_in;
    end else begin
      scc_d[wr_wave_s] = scc_q[wr_wave_s];
    end
  end

  // Read lanes from the post-write image; unbacked addresses read as 0.
  always_comb begin
    lane_addr_s[0] = bus.rd_addr0;
    lane_addr_s[1] = bus.rd_addr0 + 8'd1;
    lane_addr_s[2] = bus.rd_addr1;
    lane_addr_s[3] = bus.rd_addr1 + 8'd1;
    lane_addr_s[4] = VCC_LO;
    lane_addr_s[5] = VCC_HI;
    lane_addr_s[6] = EXEC_LO;
    lane_addr_s[7] = EXEC_HI;
    for (int i = 0; i < 8; i++) begin
      if (is_writable(lane_addr_s[i], NUM_SGPR)) begin
        lane_val_s[i] = regs_d[rd_wave_s][lane_addr_s[i][6:0]];
      end else begin
        lane_val_s[i] = 32'h0;
      end
    end
    vcc_s   = {lane_val_s[5], lane_val_s[4]};
    exec_s  = {lane_val_s[7], lane_val_s[6]};
    vccz_s  = (vcc_s == 64'h0);
    execz_s = (exec_s == 64'h0);
    scc_s   = scc_d[rd_wave_s];
  end

  // Next read outputs: capture on rd_valid, otherwise hold.
  always_comb begin
    rd_ready_d = bus.rd_valid;
    if (bus.rd_valid) begin
      rd_data0_d = sel_port(bus.rd_addr0, bus.rd_wide0, lane_val_s[0], lane_val_s[1],
                            c0_hit_s, c0_val_s, vccz_s, execz_s, scc_s, NUM_SGPR);
      rd_data1_d = sel_port(bus.rd_addr1, bus.rd_wide1, lane_val_s[2], lane_val_s[3],
                            c1_hit_s, c1_val_s, vccz_s, execz_s, scc_s, NUM_SGPR);
      exec_d     = exec_s;
      scc_out_d  = scc_s;
      vccz_d     = vccz_s;
      execz_d    = execz_s;
    end else begin
      rd_data0_d = rd_data0_q;
      rd_data1_d = rd_data1_q;
      exec_d     = exec_q;
      scc_out_d  = scc_out_q;
      vccz_d     = vccz_q;
      execz_d    = execz_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WAVES; w++) begin
        for (int r = 0; r < BANK_WORDS; r++) begin
          regs_q[w][r] <= 32'h0;
        end
      end
      scc_q      <= '0;
      wr_err_q   <= 1'b0;
      rd_ready_q <= 1'b0;
      rd_data0_q <= 64'h0;
      rd_data1_q <= 64'h0;
      exec_q     <= 64'h0;
      scc_out_q  <= 1'b0;
      vccz_q     <= 1'b1;
      execz_q    <= 1'b1;
    end else begin
      regs_q     <= regs_d;
      scc_q      <= scc_d;
      wr_err_q   <= wr_err_d;
      rd_ready_q <= rd_ready_d;
      rd_data0_q <= rd_data0_d;
      rd_data1_q <= rd_data1_d;
      exec_q     <= exec_d;
      scc_out_q  <= scc_out_d;
      vccz_q     <= vccz_d;
      execz_q    <= execz_d;
    end
  end

  assign bus.rd_data0  = rd_data0_q;
  assign bus.rd_data1  = rd_data1_q;
  assign bus.rd_ready  = rd_ready_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.exec_out  = exec_q;
  assign bus.scc_out   = scc_out_q;
  assign bus.vccz_out  = vccz_q;
  assign bus.execz_out = execz_q;

endmodule

// File: tb/tb_sgpr_bank_file.sv
// Scoreboard bench for sgpr_bank_file: a stimulus process applies each
// cycle to an array-based reference model and queues the expected
// response; a monitor pops and compares whenever a clock edge has passed.
module tb_sgpr_bank_file;

  localparam int NW = 4;
  localparam int NS = 106;

  logic clock;
  logic reset_n;

  sgpr_bank_file_if #(.WAVE_W(2)) bus ();

  sgpr_bank_file #(.NUM_WAVES(NW), .NUM_SGPR(NS), .WAVE_W(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] exec;
    logic        scc;
    logic        vccz;
    logic        execz;
  } rd_exp_t;

  typedef struct {
    logic rdy;
    logic err;
  } cyc_exp_t;

  rd_exp_t  rd_q[$];
  cyc_exp_t cyc_q[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model: plain arrays indexed by wave and operand address.
  logic [31:0] m_mem [NW][128];
  bit          m_scc [NW];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_writable(int a);
    return (a < NS) || a == 106 || a == 107 || a == 124 || a == 126 || a == 127;
  endfunction

  function automatic logic [63:0] m_read(int w, int a, bit wide);
    logic [31:0] lo, hi;
    longint      v;
    logic [63:0] vcc, ex;
    vcc = {m_mem[w][107], m_mem[w][106]};
    ex  = {m_mem[w][127], m_mem[w][126]};
    if (m_writable(a)) begin
      lo = m_mem[w][a];
      hi = m_writable(a + 1) ? m_mem[w][a + 1] : 32'h0;
      return wide ? {hi, lo} : {32'h0, lo};
    end
    if (a >= 128 && a <= 208) begin
      v = (a <= 192) ? longint'(a - 128) : longint'(192 - a);
      return wide ? 64'(v) : {32'h0, 32'(v)};
    end
    if (a == 251) return {63'h0, vcc == 64'h0};
    if (a == 252) return {63'h0, ex == 64'h0};
    if (a == 253) return {63'h0, m_scc[w]};
    return 64'h0;
  endfunction

  task automatic m_clear();
    for (int w = 0; w < NW; w++) begin
      m_scc[w] = 1'b0;
      for (int r = 0; r < 128; r++) m_mem[w][r] = 32'h0;
    end
  endtask

  task automatic drive_idle();
    bus.rd_valid = 1'b0; bus.rd_wave = 2'd0;
    bus.rd_addr0 = 8'd0; bus.rd_addr1 = 8'd0;
    bus.rd_wide0 = 1'b0; bus.rd_wide1 = 1'b0;
    bus.wr_en = 1'b0; bus.wr_wave = 2'd0; bus.wr_addr = 8'd0;
    bus.wr_wide = 1'b0; bus.wr_data = 64'h0;
    bus.scc_we = 1'b0; bus.scc_in = 1'b0;
  endtask

  // One clock of stimulus; the model applies the write first, then the read.
  task automatic step(bit rv, int rw, int a0, bit w0, int a1, bit w1,
                      bit we, int ww, int wa, bit wwide, logic [63:0] wd,
                      bit sw, bit sv);
    bit       err;
    rd_exp_t  e;
    @(negedge clock);
    bus.rd_valid = rv; bus.rd_wave = 2'(rw);
    bus.rd_addr0 = 8'(a0); bus.rd_wide0 = w0;
    bus.rd_addr1 = 8'(a1); bus.rd_wide1 = w1;
    bus.wr_en = we; bus.wr_wave = 2'(ww); bus.wr_addr = 8'(wa);
    bus.wr_wide = wwide; bus.wr_data = wd;
    bus.scc_we = sw; bus.scc_in = sv;
    err = 1'b0;
    if (we) begin
      if (wwide) begin
        if ((wa % 2 == 0) && m_writable(wa) && m_writable(wa + 1)) begin
          m_mem[ww][wa]     = wd[31:0];
          m_mem[ww][wa + 1] = wd[63:32];
        end else begin
          err = 1'b1;
        end
      end else if (m_writable(wa)) begin
        m_mem[ww][wa] = wd[31:0];
      end else begin
        err = 1'b1;
      end
    end
    if (sw) m_scc[ww] = sv;
    cyc_q.push_back('{rdy: rv, err: err});
    if (rv) begin
      e.d0    = m_read(rw, a0, w0);
      e.d1    = m_read(rw, a1, w1);
      e.exec  = {m_mem[rw][127], m_mem[rw][126]};
      e.scc   = m_scc[rw];
      e.vccz  = ({m_mem[rw][107], m_mem[rw][106]} == 64'h0);
      e.execz = (e.exec == 64'h0);
      rd_q.push_back(e);
    end
  endtask

  task automatic rd(int rw, int a0, bit w0, int a1, bit w1);
    step(1'b1, rw, a0, w0, a1, w1, 1'b0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(int ww, int wa, bit wwide, logic [63:0] wd);
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, ww, wa, wwide, wd, 1'b0, 1'b0);
  endtask

  task automatic drain();
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);
    drive_idle();
    for (int i = 0; i < 20; i++) begin
      if (cyc_q.size() == 0) break;
      @(posedge clock); #2;
    end
    chk("drain_cyc_q", 64'(cyc_q.size()), 64'd0);
    chk("drain_rd_q", 64'(rd_q.size()), 64'd0);
  endtask

  function automatic int rand_rd_addr();
    case ($urandom_range(0, 7))
      0, 1, 2: return $urandom_range(0, NS - 1);
      3:       return 124 + $urandom_range(0, 3);
      4:       return 106 + $urandom_range(0, 1);
      5:       return $urandom_range(128, 208);
      6:       return $urandom_range(251, 253);
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  function automatic int rand_wr_addr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return $urandom_range(0, NS - 1);
      4:          return 106 + $urandom_range(0, 1);
      5:          return 126 + $urandom_range(0, 1);
      6:          return 124;
      default:    return $urandom_range(0, 255);
    endcase
  endfunction

  // Monitor: one expected cycle record per clock edge while enabled.
  initial begin
    cyc_exp_t c;
    rd_exp_t  e;
    forever begin
      @(posedge clock); #1;
      if (mon_en && cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("rd_ready", 64'(bus.rd_ready), 64'(c.rdy));
        chk("wr_err", 64'(bus.wr_err), 64'(c.err));
        if (c.rdy) begin
          if (rd_q.size() == 0) begin
            chk("rd_q_underflow", 64'd1, 64'd0);
          end else begin
            e = rd_q.pop_front();
            chk("rd_data0", bus.rd_data0, e.d0);
            chk("rd_data1", bus.rd_data1, e.d1);
            chk("exec_out", bus.exec_out, e.exec);
            chk("scc_out", 64'(bus.scc_out), 64'(e.scc));
            chk("vccz_out", 64'(bus.vccz_out), 64'(e.vccz));
            chk("execz_out", 64'(bus.execz_out), 64'(e.execz));
          end
        end
      end
    end
  end

  task automatic chk_reset_values(string tag);
    chk({tag, "_rd_ready"}, 64'(bus.rd_ready), 64'd0);
    chk({tag, "_wr_err"}, 64'(bus.wr_err), 64'd0);
    chk({tag, "_rd_data0"}, bus.rd_data0, 64'd0);
    chk({tag, "_rd_data1"}, bus.rd_data1, 64'd0);
    chk({tag, "_exec_out"}, bus.exec_out, 64'd0);
    chk({tag, "_scc_out"}, 64'(bus.scc_out), 64'd0);
    chk({tag, "_vccz_out"}, 64'(bus.vccz_out), 64'd1);
    chk({tag, "_execz_out"}, 64'(bus.execz_out), 64'd1);
  endtask

  initial begin
    int rw, ww, wa;
    bit wwide;
    logic [63:0] wd;

    reset_n = 1'b0;
    drive_idle();
    m_clear();
    repeat (3) @(posedge clock);
    #1 chk_reset_values("reset");
    @(negedge clock);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Test 1: fresh EXEC reads zero, both flags set.
    rd(0, 126, 1'b1, 252, 1'b0);
    // Test 2: wide write and read back on another port; other wave untouched.
    wr(2, 10, 1'b1, 64'hDEAD_BEEF_0123_4567);
    rd(2, 0, 1'b0, 10, 1'b1);
    rd(1, 0, 1'b0, 10, 1'b1);
    // Test 3: same-cycle write and read of the same word.
    step(1'b1, 0, 4, 1'b0, 5, 1'b0, 1'b1, 0, 4, 1'b0, 64'h0000_0000_0000_00A5, 1'b0, 1'b0);
    // Bypass on the high half only of a wide read.
    step(1'b1, 1, 20, 1'b1, 21, 1'b0, 1'b1, 1, 21, 1'b0, 64'h0000_0000_CAFE_F00D, 1'b0, 1'b0);
    // Test 4: illegal narrow and odd wide writes are dropped with an error pulse.
    wr(0, 12, 1'b0, 64'h0000_0000_1234_5678);
    wr(0, 130, 1'b0, 64'h0000_0000_FFFF_0000);
    wr(0, 11, 1'b1, 64'h1111_2222_3333_4444);
    wr(0, 124, 1'b1, 64'h5555_6666_7777_8888);
    rd(0, 12, 1'b0, 11, 1'b0);
    // Test 5: constants and EXEC-derived flag.
    rd(3, 193, 1'b1, 192, 1'b0);
    rd(3, 208, 1'b1, 128, 1'b1);
    rd(3, 200, 1'b0, 253, 1'b0);
    wr(3, 126, 1'b0, 64'h1);
    wr(3, 127, 1'b0, 64'h0);
    rd(3, 252, 1'b0, 127, 1'b0);
    // VCC wide write then flag read; SCC with a simultaneous write.
    wr(1, 106, 1'b1, 64'h8000_0000_0000_0000);
    step(1'b1, 1, 251, 1'b0, 253, 1'b0, 1'b1, 1, 124, 1'b0, 64'h77, 1'b1, 1'b1);
    rd(1, 124, 1'b0, 106, 1'b1);
    drain();

    // Randomized traffic with a bias towards read/write address collisions.
    for (int n = 0; n < 400; n++) begin
      rw    = $urandom_range(0, NW - 1);
      ww    = ($urandom_range(0, 1) == 0) ? rw : $urandom_range(0, NW - 1);
      wa    = rand_wr_addr();
      wwide = $urandom_range(0, 1);
      if (wwide && $urandom_range(0, 3) != 0) wa = wa & ~1;
      wd    = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        step(1'b1, rw, wa, $urandom_range(0, 1), wa + 1, 1'b0,
             $urandom_range(0, 3) != 0, ww, wa, wwide, wd,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1));
      end else begin
        step($urandom_range(0, 3) != 0, rw, rand_rd_addr(), $urandom_range(0, 1),
             rand_rd_addr(), $urandom_range(0, 1),
             $urandom_range(0, 1), ww, wa, wwide, wd,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1));
      end
    end
    drain();

    // Test 6: reset asserted while a read is being issued.
    mon_en = 1'b0;
    @(negedge clock);
    bus.rd_valid = 1'b1; bus.rd_addr0 = 8'd126; bus.rd_wide0 = 1'b1;
    reset_n = 1'b0;
    #1 chk_reset_values("midreset");
    @(posedge clock); #1;
    chk_reset_values("midreset_edge");
    @(negedge clock);
    drive_idle();
    reset_n = 1'b1;
    m_clear();
    cyc_q.delete();
    rd_q.delete();
    mon_en = 1'b1;
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0);
    rd(2, 10, 1'b1, 253, 1'b0);
    rd(3, 252, 1'b0, 126, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
